sprite_compositor: RTL and testbench
====================================

SPRITE_COMPOSITOR -- requirements
Module: sprite_compositor

Interface
REQ-001 Parameters: NSPR=4, number of sprite layers; COLOR_W=16, pixel width; SCR_W=640, SCR_H=480, background size; MEM_LAT=1, read latency of background and sprite memories in cycles (1..3); KEY=16'h0000, transparent colour; BORDER=16'hFFFF, out-of-map colour.
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 pix_valid  in  1  pixel request this cycle; posX  in  10, posY  in  9  world pixel coordinate.
REQ-005 cx  in  10, cy  in  9  camera centre (world coordinates).
REQ-006 frame_start  in  1  one-cycle pulse marking frame boundary.
REQ-007 cfg_we  in  1, cfg_idx  in  clog2(NSPR), cfg_en  in  1, cfg_x  in  10, cfg_y  in  9, cfg_w  in  7, cfg_h  in  7, cfg_base  in  12  sprite shadow-register write.
REQ-008 bg_addr  out  19, bg_data  in  COLOR_W  background memory port, data MEM_LAT cycles after address.
REQ-009 spr_addr  out  NSPR*12, spr_data  in  NSPR*COLOR_W  one read port per sprite, same latency.
REQ-010 ocolor  out  COLOR_W, ocolor_valid  out  1  composited pixel.

Function
REQ-011 Each sprite SHALL have shadow and active register sets {en,x,y,w,h,base}; cfg_we writes shadow[cfg_idx].
REQ-012 On frame_start all shadow sets SHALL copy to active in one cycle; same-cycle cfg_we SHALL land in shadow only and take effect at the next frame_start.
REQ-013 Stage 0 (pix_valid cycle): per sprite compute dx=posX-x, dy=posY-y in 11/10-bit signed; hit = en & 0<=dx<w & 0<=dy<h; spr_addr = base + dy*w + dx (mod 2^12).
REQ-014 Stage 0: rx = SCR_W/2 + posX - cx, ry = SCR_H/2 + posY - cy in 12-bit signed; in_map = 0<=rx<SCR_W & 0<=ry<SCR_H; bg_addr = ry*SCR_W + rx when in_map, else 0.
REQ-015 Signed comparisons SHALL be used throughout; negative offsets SHALL never alias as in-range.
REQ-016 hit flags, in_map and pix_valid SHALL be delayed MEM_LAT cycles to align with memory data.
REQ-017 Output stage: ocolor = spr_data of lowest-index sprite with hit and spr_data!=KEY; else bg_data if in_map; else BORDER.
REQ-018 Latency: ocolor_valid SHALL assert exactly MEM_LAT+1 cycles after pix_valid; fully pipelined, one pixel per cycle, no stalls.
REQ-019 ocolor SHALL hold its last value while ocolor_valid is low.
REQ-020 Sprite with w=0 or h=0 SHALL never hit; overlapping sprites resolved only by REQ-017 priority.
REQ-021 Active set change on frame_start SHALL affect only pixels whose pix_valid is at or after the frame_start cycle +1; pixels already in the pipeline complete with the old set.

Reset
REQ-022 rst SHALL clear all shadow and active en bits, x/y/w/h/base to 0, pipeline valid bits to 0, ocolor to 0, ocolor_valid to 0, bg_addr and spr_addr to 0.
REQ-023 rst mid-stream SHALL discard in-flight pixels; no ocolor_valid for MEM_LAT+1 cycles after rst deasserts unless new pix_valid.

Verification
REQ-024 No sprites, cx=320, cy=240, posX=5, posY=7 -> bg_addr=4485, ocolor=bg_data, ocolor_valid at cycle MEM_LAT+1.
REQ-025 cx=0, posX=0 -> rx=320 in map; cx=639, posX=0 -> rx=-319, ocolor=16'hFFFF.
REQ-026 Sprite0 {en,x=100,y=50,w=8,h=8,base=64} committed by frame_start; posX=103,posY=52 -> spr_addr0=83, ocolor=spr_data0; posX=108 -> background.
REQ-027 Sprites 0 and 1 overlap; spr_data0=KEY -> ocolor=spr_data1; spr_data0=16'h1234 -> 16'h1234.
REQ-028 cfg_we for sprite 2 coincident with frame_start -> not visible this frame, visible after next frame_start.
REQ-029 Back-to-back pix_valid for 16 cycles with rst asserted at cycle 8 -> ocolor_valid low during rst and after until new requests; outputs at reset values.

Source files
------------

// File: rtl/sprite_compositor_if.sv
// Pixel request / composited colour bus of sprite_compositor.
// The requester drives position and strobe, the compositor returns the colour.
interface sprite_compositor_if #(
    parameter int COLOR_W = 16
);
    logic               pix_valid;
    logic [9:0]         posX;
    logic [8:0]         posY;
    logic [COLOR_W-1:0] ocolor;
    logic               ocolor_valid;

    modport master (output pix_valid, posX, posY, input ocolor, ocolor_valid);
    modport slave  (input pix_valid, posX, posY, output ocolor, ocolor_valid);
endinterface

// File: rtl/sprite_compositor.sv
// Sprite-over-background compositor: camera-relative background lookup plus
// NSPR double-buffered sprite layers, one pixel per cycle, latency MEM_LAT+1.
module sprite_compositor #(
    parameter int                 NSPR    = 4,
    parameter int                 COLOR_W = 16,
    parameter int                 SCR_W   = 640,
    parameter int                 SCR_H   = 480,
    parameter int                 MEM_LAT = 1,
    parameter logic [COLOR_W-1:0] KEY     = '0,
    parameter logic [COLOR_W-1:0] BORDER  = '1,
    localparam int                IDX_W   = (NSPR > 1) ? $clog2(NSPR) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    sprite_compositor_if.slave      pix,
    input  logic [9:0]              cx,
    input  logic [8:0]              cy,
    input  logic                    frame_start,
    input  logic                    cfg_we,
    input  logic [IDX_W-1:0]        cfg_idx,
    input  logic                    cfg_en,
    input  logic [9:0]              cfg_x,
    input  logic [8:0]              cfg_y,
    input  logic [6:0]              cfg_w,
    input  logic [6:0]              cfg_h,
    input  logic [11:0]             cfg_base,
    output logic [18:0]             bg_addr,
    input  logic [COLOR_W-1:0]      bg_data,
    output logic [NSPR*12-1:0]      spr_addr,
    input  logic [NSPR*COLOR_W-1:0] spr_data
);

    typedef struct packed {
        logic        en;
        logic [9:0]  x;
        logic [8:0]  y;
        logic [6:0]  w;
        logic [6:0]  h;
        logic [11:0] base;
    } spr_cfg_t;

    typedef struct packed {
        logic            valid;
        logic            in_map;
        logic [NSPR-1:0] hit;
    } stage_t;

    localparam logic signed [11:0] HALF_W  = 12'(SCR_W / 2);
    localparam logic signed [11:0] HALF_H  = 12'(SCR_H / 2);
    localparam logic signed [11:0] SCR_W_S = 12'(SCR_W);
    localparam logic signed [11:0] SCR_H_S = 12'(SCR_H);

    spr_cfg_t           shadow [NSPR];
    spr_cfg_t           active [NSPR];

    logic signed [11:0] rx;
    logic signed [11:0] ry;
    logic               in_map0;
    logic [NSPR-1:0]    hit0;
    logic signed [10:0] dx [NSPR];
    logic signed [9:0]  dy [NSPR];

    stage_t             pipe [MEM_LAT];
    stage_t             last;
    logic [COLOR_W-1:0] sel_color;
    logic               found;

    // frame_start copies the pre-edge shadow, so a coincident write waits a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NSPR; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            if (frame_start) begin
                for (int unsigned i = 0; i < NSPR; i++)
                    active[i] <= shadow[i];
            end
            if (cfg_we)
                shadow[cfg_idx] <= {cfg_en, cfg_x, cfg_y, cfg_w, cfg_h, cfg_base};
        end
    end

    // Stage-0 addresses are combinational so that data returned MEM_LAT cycles
    // later is registered into ocolor exactly MEM_LAT+1 cycles after the request.
    always_comb begin
        rx       = HALF_W + {2'b00, pix.posX} - {2'b00, cx};
        ry       = HALF_H + {3'b000, pix.posY} - {3'b000, cy};
        in_map0  = (rx >= 12'sd0) && (rx < SCR_W_S) && (ry >= 12'sd0) && (ry < SCR_H_S);
        bg_addr  = '0;
        if (!rst && in_map0)
            bg_addr = 19'($unsigned(ry)) * 19'(SCR_W) + 19'($unsigned(rx));

        spr_addr = '0;
        hit0     = '0;
        for (int unsigned i = 0; i < NSPR; i++) begin
            dx[i]   = $signed({1'b0, pix.posX}) - $signed({1'b0, active[i].x});
            dy[i]   = $signed({1'b0, pix.posY}) - $signed({1'b0, active[i].y});
            hit0[i] = active[i].en
                    && (dx[i] >= 11'sd0) && (dx[i] < $signed({4'b0000, active[i].w}))
                    && (dy[i] >= 10'sd0) && (dy[i] < $signed({3'b000, active[i].h}));
            if (!rst)
                spr_addr[i*12 +: 12] = active[i].base
                                     + 12'(dy[i]) * {5'b00000, active[i].w}
                                     + 12'(dx[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < MEM_LAT; i++)
                pipe[i] <= '0;
        end else begin
            pipe[0] <= '{valid: pix.pix_valid, in_map: in_map0, hit: hit0};
            for (int unsigned i = 1; i < MEM_LAT; i++)
                pipe[i] <= pipe[i-1];
        end
    end

    assign last = pipe[MEM_LAT-1];

    // lowest-index opaque sprite wins, then background, then border
    always_comb begin
        sel_color = last.in_map ? bg_data : BORDER;
        found     = 1'b0;
        for (int unsigned i = 0; i < NSPR; i++) begin
            if (!found && last.hit[i] && (spr_data[i*COLOR_W +: COLOR_W] != KEY)) begin
                sel_color = spr_data[i*COLOR_W +: COLOR_W];
                found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix.ocolor       <= '0;
            pix.ocolor_valid <= 1'b0;
        end else begin
            pix.ocolor_valid <= last.valid;
            if (last.valid)
                pix.ocolor <= sel_color;
        end
    end

endmodule

// File: tb/tb_sprite_compositor.sv
// Self-checking bench for sprite_compositor: directed scenarios plus random
// traffic compared against a per-pixel reference model and a memory model.
module tb_sprite_compositor;

    localparam int          LAT  = 2;
    localparam int          NS   = 4;
    localparam int          MAXC = 4096;
    localparam logic [15:0] KEYC = 16'h0000;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [9:0]  cx;
    logic [8:0]  cy;
    logic        frame_start;
    logic        cfg_we;
    logic [1:0]  cfg_idx;
    logic        cfg_en;
    logic [9:0]  cfg_x;
    logic [8:0]  cfg_y;
    logic [6:0]  cfg_w;
    logic [6:0]  cfg_h;
    logic [11:0] cfg_base;
    logic [18:0] bg_addr;
    logic [15:0] bg_data;
    logic [47:0] spr_addr;
    logic [63:0] spr_data;

    sprite_compositor_if #(.COLOR_W(16)) pix ();

    sprite_compositor #(
        .NSPR   (NS),
        .COLOR_W(16),
        .MEM_LAT(LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pix        (pix.slave),
        .cx         (cx),
        .cy         (cy),
        .frame_start(frame_start),
        .cfg_we     (cfg_we),
        .cfg_idx    (cfg_idx),
        .cfg_en     (cfg_en),
        .cfg_x      (cfg_x),
        .cfg_y      (cfg_y),
        .cfg_w      (cfg_w),
        .cfg_h      (cfg_h),
        .cfg_base   (cfg_base),
        .bg_addr    (bg_addr),
        .bg_data    (bg_data),
        .spr_addr   (spr_addr),
        .spr_data   (spr_data)
    );

    // ---------------- memory model: data LAT cycles after address ----------
    logic [15:0] spr_mem [NS][4096];
    logic [18:0] bg_pipe [LAT];
    logic [47:0] sa_pipe [LAT];

    function automatic logic [15:0] bg_fn(input logic [18:0] a);
        logic [31:0] t;
        t = {13'd0, a} * 32'h9E3779B1;
        return t[31:16] ^ a[15:0];
    endfunction

    always @(posedge clk) begin
        bg_pipe[0] <= bg_addr;
        sa_pipe[0] <= spr_addr;
        for (int i = 1; i < LAT; i++) begin
            bg_pipe[i] <= bg_pipe[i-1];
            sa_pipe[i] <= sa_pipe[i-1];
        end
    end

    assign bg_data = bg_fn(bg_pipe[LAT-1]);

    always_comb begin
        spr_data = '0;
        for (int s = 0; s < NS; s++)
            spr_data[s*16 +: 16] = spr_mem[s][sa_pipe[LAT-1][s*12 +: 12]];
    end

    // ---------------- reference model ----------------------------------------
    typedef struct {
        bit en;
        int x, y, w, h, base;
    } cfg_t;

    cfg_t        m_sh  [NS];
    cfg_t        m_act [NS];
    bit          exp_v [MAXC];
    logic [15:0] exp_c [MAXC];
    bit          m_ov;
    logic [15:0] m_oc;
    int          edge_n;
    int          checks;
    int          failures;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit ref_in_map(input int px, input int py);
        int rx, ry;
        rx = 320 + px - int'(cx);
        ry = 240 + py - int'(cy);
        return rx >= 0 && rx < 640 && ry >= 0 && ry < 480;
    endfunction

    function automatic int ref_bg_addr(input int px, input int py);
        if (!ref_in_map(px, py)) return 0;
        return (240 + py - int'(cy)) * 640 + (320 + px - int'(cx));
    endfunction

    function automatic bit ref_hit(input int s, input int px, input int py);
        int dx, dy;
        dx = px - m_act[s].x;
        dy = py - m_act[s].y;
        return m_act[s].en && dx >= 0 && dx < m_act[s].w && dy >= 0 && dy < m_act[s].h;
    endfunction

    function automatic int ref_spr_addr(input int s, input int px, input int py);
        int a;
        a = m_act[s].base + (py - m_act[s].y) * m_act[s].w + (px - m_act[s].x);
        return ((a % 4096) + 4096) % 4096;
    endfunction

    function automatic logic [15:0] ref_color(input int px, input int py);
        for (int s = 0; s < NS; s++)
            if (ref_hit(s, px, py) && spr_mem[s][ref_spr_addr(s, px, py)] != KEYC)
                return spr_mem[s][ref_spr_addr(s, px, py)];
        if (ref_in_map(px, py)) return bg_fn(19'(ref_bg_addr(px, py)));
        return 16'hFFFF;
    endfunction

    // One clock: check stage-0 addresses, advance the model by one edge, then
    // compare registered outputs on the falling edge.
    task automatic tick();
        int px, py;
        px = int'(pix.posX);
        py = int'(pix.posY);
        #1;
        if (rst) begin
            check("bg_addr_rst", 32'(bg_addr), 32'd0);
            check("spr_addr_rst", spr_addr[31:0], 32'd0);
        end else if (pix.pix_valid) begin
            check("bg_addr", 32'(bg_addr), 32'(ref_bg_addr(px, py)));
            for (int s = 0; s < NS; s++)
                check("spr_addr", 32'(spr_addr[s*12 +: 12]), 32'(ref_spr_addr(s, px, py)));
        end

        if (rst) begin
            for (int j = edge_n; j <= edge_n + LAT; j++) exp_v[j] = 1'b0;
            for (int s = 0; s < NS; s++) begin
                m_sh[s]  = '{0, 0, 0, 0, 0, 0};
                m_act[s] = '{0, 0, 0, 0, 0, 0};
            end
            m_ov = 1'b0;
            m_oc = '0;
        end else begin
            if (pix.pix_valid) begin
                exp_v[edge_n + LAT] = 1'b1;
                exp_c[edge_n + LAT] = ref_color(px, py);
            end
            m_ov = exp_v[edge_n];
            if (m_ov) m_oc = exp_c[edge_n];
            if (frame_start) m_act = m_sh;
            if (cfg_we)
                m_sh[cfg_idx] = '{cfg_en, int'(cfg_x), int'(cfg_y), int'(cfg_w),
                                  int'(cfg_h), int'(cfg_base)};
        end

        @(posedge clk);
        @(negedge clk);
        check("ocolor_valid", 32'(pix.ocolor_valid), 32'(m_ov));
        check("ocolor", 32'(pix.ocolor), 32'(m_oc));
        edge_n++;
    endtask

    task automatic idle(input int n);
        pix.pix_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic req(input int x, input int y);
        pix.pix_valid = 1'b1;
        pix.posX      = 10'(x);
        pix.posY      = 9'(y);
        tick();
        pix.pix_valid = 1'b0;
    endtask

    task automatic set_cfg(input int idx, input bit en, input int x, input int y,
                           input int w, input int h, input int base);
        cfg_idx  = 2'(idx);
        cfg_en   = en;
        cfg_x    = 10'(x);
        cfg_y    = 9'(y);
        cfg_w    = 7'(w);
        cfg_h    = 7'(h);
        cfg_base = 12'(base);
    endtask

    task automatic wr_cfg(input int idx, input bit en, input int x, input int y,
                          input int w, input int h, input int base);
        set_cfg(idx, en, x, y, w, h, base);
        cfg_we = 1'b1;
        tick();
        cfg_we = 1'b0;
    endtask

    task automatic fstart();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        edge_n = 0;
        m_ov = 1'b0;
        m_oc = '0;
        for (int s = 0; s < NS; s++)
            for (int a = 0; a < 4096; a++)
                spr_mem[s][a] = ($urandom % 4 == 0) ? KEYC : 16'($urandom);

        rst = 1'b1;
        cx = 10'd320;
        cy = 9'd240;
        frame_start = 1'b0;
        cfg_we = 1'b0;
        set_cfg(0, 1'b0, 0, 0, 0, 0, 0);
        pix.pix_valid = 1'b0;
        pix.posX = '0;
        pix.posY = '0;
        repeat (3) tick();
        rst = 1'b0;
        idle(2);

        // centred camera, no sprites
        pix.pix_valid = 1'b1;
        pix.posX = 10'd5;
        pix.posY = 9'd7;
        #1 check("req024_bg_addr", 32'(bg_addr), 32'd4485);
        tick();
        idle(LAT + 2);
        check("req024_color", 32'(pix.ocolor), 32'(bg_fn(19'd4485)));

        // camera extremes
        cx = 10'd0;
        req(0, 240);
        cx = 10'd639;
        req(0, 240);
        idle(LAT + 2);
        check("req025_border", 32'(pix.ocolor), 32'hFFFF);
        cx = 10'd320;
        cy = 9'd240;

        // single sprite hit and just-outside miss
        spr_mem[0][83] = 16'hBEEF;
        wr_cfg(0, 1'b1, 100, 50, 8, 8, 64);
        fstart();
        pix.pix_valid = 1'b1;
        pix.posX = 10'd103;
        pix.posY = 9'd52;
        #1 check("req026_spr_addr0", 32'(spr_addr[11:0]), 32'd83);
        tick();
        idle(LAT + 2);
        check("req026_sprite", 32'(pix.ocolor), 32'hBEEF);
        req(108, 52);
        idle(LAT + 2);
        check("req026_bg", 32'(pix.ocolor), 32'(bg_fn(19'(52 * 640 + 108))));

        // overlap with transparent / opaque upper sprite
        spr_mem[0][83]  = KEYC;
        spr_mem[1][531] = 16'h5A5A;
        wr_cfg(1, 1'b1, 100, 50, 8, 8, 512);
        fstart();
        req(103, 52);
        idle(LAT + 2);
        check("req027_key", 32'(pix.ocolor), 32'h5A5A);
        spr_mem[0][83] = 16'h1234;
        req(103, 52);
        idle(LAT + 2);
        check("req027_prio", 32'(pix.ocolor), 32'h1234);

        // config write coincident with frame_start is deferred a frame
        spr_mem[2][1085] = 16'hC0DE;
        set_cfg(2, 1'b1, 200, 100, 16, 16, 1000);
        cfg_we = 1'b1;
        frame_start = 1'b1;
        pix.pix_valid = 1'b1;
        pix.posX = 10'd205;
        pix.posY = 9'd105;
        tick();
        cfg_we = 1'b0;
        frame_start = 1'b0;
        req(205, 105);
        idle(LAT + 2);
        check("req028_hidden", 32'(pix.ocolor), 32'(bg_fn(19'(105 * 640 + 205))));
        frame_start = 1'b1;
        pix.pix_valid = 1'b1;
        tick();
        frame_start = 1'b0;
        req(205, 105);
        idle(LAT + 2);
        check("req028_visible", 32'(pix.ocolor), 32'hC0DE);

        // zero-width sprite never hits
        wr_cfg(3, 1'b1, 300, 300, 0, 8, 0);
        fstart();
        req(300, 300);
        idle(LAT + 2);

        // random traffic
        for (int n = 0; n < 600; n++) begin
            int s;
            cfg_we = ($urandom % 8 == 0);
            if (cfg_we)
                set_cfg(int'($urandom % 4), ($urandom % 4 != 0), int'($urandom % 1024),
                        int'($urandom % 512),
                        ($urandom % 8 == 0) ? 0 : int'($urandom % 128),
                        ($urandom % 8 == 0) ? 0 : int'($urandom % 128),
                        int'($urandom % 4096));
            frame_start = ($urandom % 16 == 0);
            if ($urandom % 32 == 0) begin
                cx = 10'($urandom);
                cy = 9'($urandom);
            end
            pix.pix_valid = ($urandom % 4 != 0);
            s = int'($urandom % 4);
            if ($urandom % 2 == 0) begin
                pix.posX = 10'(m_act[s].x + int'($urandom_range(0, 140)) - 6);
                pix.posY = 9'(m_act[s].y + int'($urandom_range(0, 140)) - 6);
            end else begin
                pix.posX = 10'($urandom);
                pix.posY = 9'($urandom);
            end
            tick();
        end
        cfg_we = 1'b0;
        frame_start = 1'b0;
        idle(LAT + 2);

        // reset in the middle of a back-to-back burst
        for (int n = 0; n < 16; n++) begin
            pix.pix_valid = 1'b1;
            pix.posX = 10'($urandom);
            pix.posY = 9'($urandom);
            rst = (n == 8 || n == 9);
            tick();
        end
        rst = 1'b0;
        idle(LAT + 2);
        for (int n = 0; n < 4; n++) req(int'($urandom % 1024), int'($urandom % 512));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle(LAT + 3);
        check("req029_idle_valid", 32'(pix.ocolor_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
